// File: rtl/gnss_fe_pkg.sv
// Shared definitions for the GNSS front-end sample path: the 2-bit sample type,
// its encoding, and the legal packing factors for raw record bytes.
package gnss_fe_pkg;

  typedef logic [1:0] sample_t;

  localparam int BYTE_W   = 8;
  localparam int SAMPLE_W = 2;

  // Legal packing factors: samples carried per record byte
  localparam int SPB_RAW  = 1;  // one sample per byte, bits[1:0] only
  localparam int SPB_HALF = 2;  // two samples per byte, low nibble
  localparam int SPB_FULL = 4;  // four samples per byte

  // Sign/magnitude encoding shared with the carrier wipe-off path:
  // bit 1 is the sign, bit 0 selects the large magnitude.
  localparam sample_t SAMPLE_POS_1 = 2'b00;
  localparam sample_t SAMPLE_POS_3 = 2'b01;
  localparam sample_t SAMPLE_NEG_1 = 2'b10;
  localparam sample_t SAMPLE_NEG_3 = 2'b11;

  function automatic bit spb_is_legal(input int spb);
    return (spb == SPB_RAW) || (spb == SPB_HALF) || (spb == SPB_FULL);
  endfunction

  function automatic bit fifo_depth_is_legal(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read, so the consumer can load the
// head word on the same edge that pops it. Depth must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage array, no reset so it maps onto RAM
  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Control state
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gnss_sample_unpacker.sv
// Buffers raw front-end record bytes from an AXI-Stream slave, unpacks them into
// 2-bit samples (LSB pair first) and emits them at a programmable cadence.
module gnss_sample_unpacker
  import gnss_fe_pkg::*;
#(
  parameter int FIFO_DEPTH       = 16,
  parameter int SAMPLES_PER_BYTE = 4,
  parameter int RATE_DIV_W       = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  enable,
  input  logic [RATE_DIV_W-1:0] rate_div,
  input  logic                  clear_underrun,
  output sample_t               data_out,
  output logic                  data_out_valid,
  output logic                  underrun,
  output logic [31:0]           sample_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] SPB_CNT = 3'(SAMPLES_PER_BYTE);

  generate
    if (!spb_is_legal(SAMPLES_PER_BYTE)) begin : g_bad_spb
      $error("gnss_sample_unpacker: SAMPLES_PER_BYTE must be 1, 2 or 4");
    end
    if (!fifo_depth_is_legal(FIFO_DEPTH)) begin : g_bad_depth
      $error("gnss_sample_unpacker: FIFO_DEPTH must be a power of two >= 4");
    end
  endgenerate

  // Registered state
  logic                  tready_q, tready_d;
  logic                  run_q, run_d;
  logic [RATE_DIV_W-1:0] term_q, term_d;
  logic [RATE_DIV_W-1:0] pace_q, pace_d;
  logic [7:0]            hold_byte_q, hold_byte_d;
  logic [2:0]            hold_cnt_q, hold_cnt_d;
  sample_t               data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  underrun_q, underrun_d;
  logic [31:0]           sample_count_q, sample_count_d;

  // FIFO interface
  logic                  fifo_push, fifo_pop;
  logic [7:0]            fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;

  // Pacing/unpack decode
  logic                  counting, tick, emit, starve;
  logic [RATE_DIV_W-1:0] term_new;
  logic [2:0]            hold_cnt_after;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (fifo_push),
    .wdata   (s_axis_tdata),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sample-slot decode. Ticks need enable to have been high for one cycle already,
  // which gives the holding register a cycle to load after a prefill before the
  // first slot arrives.
  always_comb begin
    counting       = enable && run_q;
    tick           = counting && (pace_q == term_q);
    emit           = tick && (hold_cnt_q != '0);
    starve         = tick && (hold_cnt_q == '0);
    hold_cnt_after = hold_cnt_q - 3'(emit);
    fifo_push      = s_axis_tvalid && tready_q && !fifo_full;
    fifo_pop       = enable && !fifo_empty && (hold_cnt_after == '0);
    term_new       = (rate_div == '0) ? '0 : (rate_div - RATE_DIV_W'(1));
  end

  // Pace counter; a new divide ratio is only picked up at a wrap or while idle
  always_comb begin
    run_d  = enable;
    pace_d = pace_q;
    term_d = term_q;
    if (!counting || tick) begin
      pace_d = '0;
      term_d = term_new;
    end else begin
      pace_d = pace_q + RATE_DIV_W'(1);
    end
  end

  // Holding register: shift out one pair per emitted sample, refill on the same edge
  // the last pair leaves so back-to-back bytes have no bubble
  always_comb begin
    hold_byte_d = hold_byte_q;
    hold_cnt_d  = hold_cnt_q;
    if (emit) begin
      hold_byte_d = hold_byte_q >> 2;
      hold_cnt_d  = hold_cnt_after;
    end
    if (fifo_pop) begin
      hold_byte_d = fifo_rdata;
      hold_cnt_d  = SPB_CNT;
    end
  end

  // Registered outputs; tready looks ahead to the next FIFO occupancy so it never
  // admits a byte into a full FIFO
  always_comb begin
    data_out_d     = data_out_q;
    valid_d        = emit;
    sample_count_d = sample_count_q;
    if (emit) begin
      data_out_d     = hold_byte_q[1:0];
      sample_count_d = sample_count_q + 32'd1;
    end
    underrun_d = underrun_q;
    if (clear_underrun) begin
      underrun_d = 1'b0;
    end
    if (starve) begin
      underrun_d = 1'b1;
    end
    tready_d = (fifo_count + CW'(fifo_push) - CW'(fifo_pop)) != CW'(FIFO_DEPTH);
  end

  // All top-level state
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tready_q       <= 1'b0;
      run_q          <= 1'b0;
      term_q         <= '0;
      pace_q         <= '0;
      hold_byte_q    <= '0;
      hold_cnt_q     <= '0;
      data_out_q     <= '0;
      valid_q        <= 1'b0;
      underrun_q     <= 1'b0;
      sample_count_q <= '0;
    end else begin
      tready_q       <= tready_d;
      run_q          <= run_d;
      term_q         <= term_d;
      pace_q         <= pace_d;
      hold_byte_q    <= hold_byte_d;
      hold_cnt_q     <= hold_cnt_d;
      data_out_q     <= data_out_d;
      valid_q        <= valid_d;
      underrun_q     <= underrun_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign s_axis_tready  = tready_q;
  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;
  assign underrun       = underrun_q;
  assign sample_count   = sample_count_q;

endmodule
